// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and output register for the common data bus.
// NUM_SRC functional units compete for one CDB beat per cycle. The winner's
// data/tag are registered onto the bus along with a one-hot source select.
// Optional build macro CDB_GRANT_STATS_EN adds per-source 16-bit saturating
// grant counters on output grant_cnt.

`ifdef CDB_GRANT_STATS_EN
// Per-source saturating grant counter.
module cdb_grant_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);
    logic [15:0] r_cnt;

    // Count completed transfers, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != 16'hFFFF))
            r_cnt <= r_cnt + 16'd1;
    end

    assign o_cnt = r_cnt;
endmodule
`endif

module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      cdb_ready,
    output logic                      cdb_valid,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [NUM_SRC-1:0]        cdb_src_sel
`ifdef CDB_GRANT_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]     grant_cnt
`endif
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_cdb_valid;
    logic [DATA_W-1:0]  r_cdb_data;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [NUM_SRC-1:0] r_cdb_src_sel;

    logic               w_load_en;
    logic               w_any;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [NUM_SRC-1:0] w_win_oh;
    logic [DATA_W-1:0]  w_win_data;
    logic [TAG_W-1:0]   w_win_tag;
    int                 w_idx;

    // Output register accepts a new beat when empty or being drained.
    assign w_load_en = !r_cdb_valid || cdb_ready;

    // Round-robin search starting at rr_ptr; first requester found wins.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        w_idx     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_SRC)
                w_idx = w_idx - NUM_SRC;
            if (!w_any && src_valid[w_idx]) begin
                w_any     = 1'b1;
                w_win_idx = PTR_W'(w_idx);
            end
        end
    end

    // One-hot of the winner plus its data/tag slice (selected by one-hot OR).
    always_comb begin
        w_win_oh   = '0;
        w_win_data = '0;
        w_win_tag  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_any && (w_win_idx == PTR_W'(i))) begin
                w_win_oh[i] = 1'b1;
                w_win_data  = w_win_data | src_data[i*DATA_W +: DATA_W];
                w_win_tag   = w_win_tag  | src_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // Explicit wrap so non-power-of-two source counts stay in range.
    assign w_next_ptr = (w_win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : w_win_idx + 1'b1;

    // Grant only when the output register can take the beat and not in reset.
    assign src_ready = (rst_n && w_load_en) ? w_win_oh : '0;

    // CDB output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid   <= 1'b0;
            r_cdb_data    <= '0;
            r_cdb_tag     <= '0;
            r_cdb_src_sel <= '0;
            r_rr_ptr      <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_cdb_valid   <= 1'b1;
                r_cdb_data    <= w_win_data;
                r_cdb_tag     <= w_win_tag;
                r_cdb_src_sel <= w_win_oh;
                r_rr_ptr      <= w_next_ptr;
            end else begin
                // Bubble: data/tag keep their last value, pointer holds.
                r_cdb_valid   <= 1'b0;
                r_cdb_src_sel <= '0;
            end
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_data    = r_cdb_data;
    assign cdb_tag     = r_cdb_tag;
    assign cdb_src_sel = r_cdb_src_sel;

`ifdef CDB_GRANT_STATS_EN
    // One saturating counter per source, bumped on each completed transfer.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_stats
        cdb_grant_ctr u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .i_inc (src_valid[g] & src_ready[g]),
            .o_cnt (grant_cnt[g*16 +: 16])
        );
    end
`else
    // Grant statistics not built in this configuration.
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_SRC=4). A queue-free reference
// model tracks the round-robin pointer as a plain integer and recomputes the
// winner by scanning offsets modulo NUM_SRC each cycle.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [N*DW-1:0] src_data;
    logic [N*TW-1:0] src_tag;
    logic [N-1:0]    src_ready;
    logic            cdb_ready;
    logic            cdb_valid;
    logic [DW-1:0]   cdb_data;
    logic [TW-1:0]   cdb_tag;
    logic [N-1:0]    cdb_src_sel;
`ifdef CDB_GRANT_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    cdb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_tag     (src_tag),
        .src_ready   (src_ready),
        .cdb_ready   (cdb_ready),
        .cdb_valid   (cdb_valid),
        .cdb_data    (cdb_data),
        .cdb_tag     (cdb_tag),
        .cdb_src_sel (cdb_src_sel)
`ifdef CDB_GRANT_STATS_EN
        ,
        .grant_cnt   (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr;
    logic        m_valid;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_tag;
    logic [N-1:0]  m_sel;
    int          m_cnt [N];
    int          last_win;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_tag = '0; m_sel = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".cdb_valid"}, 64'(cdb_valid), 64'(m_valid));
        chk({tag, ".cdb_src_sel"}, 64'(cdb_src_sel), 64'(m_sel));
        chk({tag, ".cdb_data"}, 64'(cdb_data), 64'(m_data));
        chk({tag, ".cdb_tag"}, 64'(cdb_tag), 64'(m_tag));
    endtask

    task automatic chk_stats();
`ifdef CDB_GRANT_STATS_EN
        for (int i = 0; i < N; i++)
            chk($sformatf("grant_cnt[%0d]", i), 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    endtask

    // One clock cycle: drive at negedge, check grant, clock, check outputs.
    task automatic cyc(input logic [N-1:0] v, input logic r, input string tag);
        int w;
        logic le;
        logic [N-1:0] exp_rdy;
        src_valid = v;
        cdb_ready = r;
        for (int i = 0; i < N; i++) begin
            src_data[i*DW +: DW] = $urandom();
            src_tag[i*TW +: TW]  = TW'($urandom());
        end
        #1;
        le = !m_valid || r;
        w  = le ? winner(v, m_ptr) : -1;
        exp_rdy = (w >= 0) ? N'(1 << w) : '0;
        chk({tag, ".src_ready"}, 64'(src_ready), 64'(exp_rdy));
        last_win = w;
        @(posedge clk);
        if (le) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = src_data[w*DW +: DW];
                m_tag   = src_tag[w*TW +: TW];
                m_sel   = N'(1 << w);
                m_ptr   = (w + 1) % N;
                if (m_cnt[w] < 65535) m_cnt[w]++;
            end else begin
                m_valid = 1'b0;
                m_sel   = '0;
            end
        end
        @(negedge clk);
        chk_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0; src_valid = '1; cdb_ready = 1'b1; src_data = '0; src_tag = '0;
        for (int i = 0; i < N; i++) begin
            src_data[i*DW +: DW] = DW'(32'hA000_0000 + i);
            src_tag[i*TW +: TW]  = TW'(i + 8);
        end
        model_reset();
        last_win = -1;

        // Reset with all sources requesting: nothing granted, outputs zero.
        repeat (2) @(negedge clk);
        chk("reset.src_ready", 64'(src_ready), 64'h0);
        chk_outputs("reset");
        chk_stats();
        rst_n = 1'b1;

        // First cycle after reset grants source 0.
        cyc(4'b1111, 1'b1, "first");
        chk("first.win", 64'(last_win), 64'd0);

        // Round robin with everyone requesting: 1,2,3,0,1,2,3,0 continues.
        for (int k = 0; k < 8; k++) begin
            cyc(4'b1111, 1'b1, "rr");
            chk("rr.order", 64'(last_win), 64'((k + 1) % N));
        end

        // Steer pointer to 3, then lone src 2 requests, then 1001 -> src 3 first.
        cyc(4'b0100, 1'b1, "p2");  // ptr was 1 -> grant 2, ptr 3
        cyc(4'b0100, 1'b1, "lone2");
        chk("lone2.win", 64'(last_win), 64'd2);
        cyc(4'b1001, 1'b1, "wrap3");
        chk("wrap3.win", 64'(last_win), 64'd3);
        cyc(4'b1001, 1'b1, "wrap0");
        chk("wrap0.win", 64'(last_win), 64'd0);

        // Stall for 3 cycles with a held beat.
        for (int k = 0; k < 3; k++) cyc(4'b1111, 1'b0, "stall");
        cyc(4'b1111, 1'b1, "unstall");
        chk("unstall.win", 64'(last_win), 64'd1);

        // Idle: bubbles, pointer kept.
        cyc(4'b0000, 1'b1, "idle0");
        cyc(4'b0000, 1'b1, "idle1");
        cyc(4'b1111, 1'b1, "after_idle");
        chk("after_idle.win", 64'(last_win), 64'd2);

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 400; k++)
            cyc(N'($urandom()), 1'($urandom_range(0, 3) != 0), "rand");
        chk_stats();

        // Reset while a beat is stalled: cleared immediately, restart at 0.
        cyc(4'b1111, 1'b1, "pre_rst");
        cyc(4'b1111, 1'b0, "pre_rst_stall");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.cdb_valid", 64'(cdb_valid), 64'd0);
        chk("midrst.cdb_src_sel", 64'(cdb_src_sel), 64'd0);
        chk("midrst.src_ready", 64'(src_ready), 64'd0);
        chk_stats();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1010, 1'b1, "post_rst");
        chk("post_rst.win", 64'(last_win), 64'd1);
        cyc(4'b1111, 1'b1, "post_rst2");
        chk("post_rst2.win", 64'(last_win), 64'd2);

`ifdef CDB_GRANT_STATS_EN
        // Saturate source 1's counter.
        rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 70000; k++) cyc(4'b0010, 1'b1, "sat");
        chk_stats();
        chk("sat.cnt1", 64'(grant_cnt[16 +: 16]), 64'hFFFF);
        rst_n = 1'b0;
        #1 model_reset();
        chk_stats();
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
